// File: rtl/strip_extractor.sv
// Collects a DIM x DIM binary frame row by row, finds the first occupied column or row,
// then streams NUM_STRIPS evenly spaced strips from that anchor over a valid/ready port.
module strip_extractor #(
    parameter int DIM        = 32,
    parameter int NUM_STRIPS = 4,
    parameter int OFFSET     = 2,
    parameter int SPACING    = 4,
    localparam int IW = $clog2(DIM),
    localparam int SW = $clog2(NUM_STRIPS),
    localparam int PW = IW + 8
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            mode_in,
    input  logic            row_valid_in,
    output logic            row_ready_out,
    input  logic [DIM-1:0]  row_data_in,
    output logic            strip_valid_out,
    input  logic            strip_ready_in,
    output logic [DIM-1:0]  strip_data_out,
    output logic [SW-1:0]   strip_index_out,
    output logic [PW-1:0]   strip_pos_out,
    output logic            strip_oob_out,
    output logic            strip_empty_out,
    output logic            strip_last_out,
    output logic            busy_out
);

    typedef enum logic [1:0] {LOAD, SCAN, EMIT} state_t;

    state_t state_q, state_d;

    logic [DIM-1:0] frame_q [DIM];
    logic [DIM-1:0] col_occ_q, col_occ_d;
    logic [DIM-1:0] row_occ_q, row_occ_d;
    logic [IW-1:0]  row_cnt_q, row_cnt_d;
    logic [IW-1:0]  scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]  anchor_q, anchor_d;
    logic [SW-1:0]  k_q, k_d;
    logic           mode_q, mode_d;
    logic           empty_q, empty_d;

    logic           row_ready_q, row_ready_d;
    logic           strip_valid_q, strip_valid_d;
    logic [DIM-1:0] strip_data_q, strip_data_d;
    logic [PW-1:0]  strip_pos_q, strip_pos_d;
    logic           strip_oob_q, strip_oob_d;
    logic           strip_last_q, strip_last_d;
    logic           busy_q, busy_d;

    logic           row_we;
    logic           load_beat;
    logic           occ_bit;
    logic [PW-1:0]  pos_calc;
    logic [IW-1:0]  pos_idx;
    logic           pos_oob;
    logic [DIM-1:0] beat_data;

    // Next-state logic; the beat presented in EMIT is computed from the next anchor/k
    // so every strip output can be registered alongside the state change.
    always_comb begin
        state_d       = state_q;
        col_occ_d     = col_occ_q;
        row_occ_d     = row_occ_q;
        row_cnt_d     = row_cnt_q;
        scan_cnt_d    = scan_cnt_q;
        anchor_d      = anchor_q;
        k_d           = k_q;
        mode_d        = mode_q;
        empty_d       = empty_q;
        row_ready_d   = row_ready_q;
        strip_valid_d = strip_valid_q;
        strip_data_d  = strip_data_q;
        strip_pos_d   = strip_pos_q;
        strip_oob_d   = strip_oob_q;
        strip_last_d  = strip_last_q;
        busy_d        = busy_q;
        row_we        = 1'b0;
        load_beat     = 1'b0;
        occ_bit       = mode_q ? row_occ_q[scan_cnt_q] : col_occ_q[scan_cnt_q];

        case (state_q)
            LOAD: begin
                if (row_valid_in && row_ready_q) begin
                    row_we               = 1'b1;
                    col_occ_d            = col_occ_q | row_data_in;
                    row_occ_d[row_cnt_q] = |row_data_in;
                    if (row_cnt_q == '0) begin
                        mode_d = mode_in;
                    end
                    if (row_cnt_q == IW'(DIM - 1)) begin
                        state_d     = SCAN;
                        row_ready_d = 1'b0;
                        busy_d      = 1'b1;
                        row_cnt_d   = '0;
                        scan_cnt_d  = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end else begin
                    row_ready_d = 1'b1;
                end
            end
            SCAN: begin
                if (occ_bit) begin
                    state_d   = EMIT;
                    anchor_d  = scan_cnt_q;
                    empty_d   = 1'b0;
                    k_d       = '0;
                    load_beat = 1'b1;
                end else if (scan_cnt_q == IW'(DIM - 1)) begin
                    state_d   = EMIT;
                    anchor_d  = '0;
                    empty_d   = 1'b1;
                    k_d       = '0;
                    load_beat = 1'b1;
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
            EMIT: begin
                if (strip_ready_in) begin
                    if (strip_last_q) begin
                        state_d       = LOAD;
                        row_ready_d   = 1'b1;
                        busy_d        = 1'b0;
                        strip_valid_d = 1'b0;
                        strip_data_d  = '0;
                        strip_pos_d   = '0;
                        strip_oob_d   = 1'b0;
                        strip_last_d  = 1'b0;
                        empty_d       = 1'b0;
                        k_d           = '0;
                        anchor_d      = '0;
                        scan_cnt_d    = '0;
                        col_occ_d     = '0;
                        row_occ_d     = '0;
                        mode_d        = 1'b0;
                    end else begin
                        k_d       = k_q + 1'b1;
                        load_beat = 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        // Position is widened so anchor + offset + k*spacing can never wrap back into range.
        pos_calc  = PW'(anchor_d) + PW'(OFFSET) + PW'(k_d) * PW'(SPACING);
        pos_idx   = pos_calc[IW-1:0];
        pos_oob   = (pos_calc >= PW'(DIM));
        beat_data = '0;
        if (mode_q) begin
            beat_data = frame_q[pos_idx];
        end else begin
            for (int i = 0; i < DIM; i++) begin
                beat_data[i] = frame_q[i][pos_idx];
            end
        end

        if (load_beat) begin
            strip_valid_d = 1'b1;
            strip_pos_d   = pos_calc;
            strip_oob_d   = pos_oob;
            strip_last_d  = (k_d == SW'(NUM_STRIPS - 1));
            strip_data_d  = (pos_oob || empty_d) ? '0 : beat_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= LOAD;
            col_occ_q     <= '0;
            row_occ_q     <= '0;
            row_cnt_q     <= '0;
            scan_cnt_q    <= '0;
            anchor_q      <= '0;
            k_q           <= '0;
            mode_q        <= 1'b0;
            empty_q       <= 1'b0;
            row_ready_q   <= 1'b0;
            strip_valid_q <= 1'b0;
            strip_data_q  <= '0;
            strip_pos_q   <= '0;
            strip_oob_q   <= 1'b0;
            strip_last_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_occ_q     <= col_occ_d;
            row_occ_q     <= row_occ_d;
            row_cnt_q     <= row_cnt_d;
            scan_cnt_q    <= scan_cnt_d;
            anchor_q      <= anchor_d;
            k_q           <= k_d;
            mode_q        <= mode_d;
            empty_q       <= empty_d;
            row_ready_q   <= row_ready_d;
            strip_valid_q <= strip_valid_d;
            strip_data_q  <= strip_data_d;
            strip_pos_q   <= strip_pos_d;
            strip_oob_q   <= strip_oob_d;
            strip_last_q  <= strip_last_d;
            busy_q        <= busy_d;
        end
    end

    // Frame storage needs no reset: every row is rewritten before a scan can read it.
    always_ff @(posedge clk_in) begin
        if (row_we) begin
            frame_q[row_cnt_q] <= row_data_in;
        end
    end

    assign row_ready_out   = row_ready_q;
    assign strip_valid_out = strip_valid_q;
    assign strip_data_out  = strip_data_q;
    assign strip_index_out = k_q;
    assign strip_pos_out   = strip_pos_q;
    assign strip_oob_out   = strip_oob_q;
    assign strip_empty_out = empty_q;
    assign strip_last_out  = strip_last_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_strip_extractor.sv
// Directed bench for strip_extractor with an 8x8 image, two strips, offset 1, spacing 2.
module tb_strip_extractor;

    localparam int DIM = 8;
    localparam int PW  = 11;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          mode_in = 1'b0;
    logic          row_valid_in = 1'b0;
    logic          row_ready_out;
    logic [7:0]    row_data_in = 8'h00;
    logic          strip_valid_out;
    logic          strip_ready_in = 1'b0;
    logic [7:0]    strip_data_out;
    logic [0:0]    strip_index_out;
    logic [PW-1:0] strip_pos_out;
    logic          strip_oob_out;
    logic          strip_empty_out;
    logic          strip_last_out;
    logic          busy_out;

    int checks = 0;
    int errors = 0;

    // Rows packed low row first: row r lives in bits [r*8 +: 8].
    localparam logic [63:0] IMG_A    = {8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h10};
    localparam logic [63:0] IMG_ZERO = 64'h0;
    localparam logic [63:0] IMG_COL7 = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00};
    localparam logic [63:0] IMG_FULL = {64{1'b1}};

    logic [23:0] beat_obs;
    assign beat_obs = {strip_valid_out, strip_data_out, strip_index_out, strip_pos_out,
                       strip_oob_out, strip_empty_out, strip_last_out};

    always #5 clk_in = ~clk_in;

    strip_extractor #(
        .DIM(DIM), .NUM_STRIPS(2), .OFFSET(1), .SPACING(2)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .mode_in(mode_in),
        .row_valid_in(row_valid_in),
        .row_ready_out(row_ready_out),
        .row_data_in(row_data_in),
        .strip_valid_out(strip_valid_out),
        .strip_ready_in(strip_ready_in),
        .strip_data_out(strip_data_out),
        .strip_index_out(strip_index_out),
        .strip_pos_out(strip_pos_out),
        .strip_oob_out(strip_oob_out),
        .strip_empty_out(strip_empty_out),
        .strip_last_out(strip_last_out),
        .busy_out(busy_out)
    );

    task automatic send_rows(input logic mode, input logic [63:0] img, input int nrows, output bit ok);
        int waited;
        ok = 1'b1;
        for (int r = 0; r < nrows; r++) begin
            mode_in      = mode;
            row_data_in  = img[r*8 +: 8];
            row_valid_in = 1'b1;
            waited = 0;
            while (row_ready_out !== 1'b1 && waited < 20) begin
                @(posedge clk_in); #1;
                waited++;
            end
            if (waited >= 20) ok = 1'b0;
            @(posedge clk_in); #1;
        end
        row_valid_in = 1'b0;
        row_data_in  = 8'h00;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (strip_valid_out !== 1'b1 && cycles < 40) begin
            @(posedge clk_in); #1;
            cycles++;
        end
    endtask

    task automatic test_reset;
        #1 rst_in = 1'b1;
        #2;
        checks++;
        if ({row_ready_out, busy_out, beat_obs} !== 26'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", {row_ready_out, busy_out, beat_obs});
        end
        @(posedge clk_in); @(posedge clk_in); #3;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (row_ready_out !== 1'b1 || busy_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release_ready: got ready=%b busy=%b expected ready=1 busy=0",
                     row_ready_out, busy_out);
        end
    endtask

    task automatic test_vertical;
        bit ok;
        int n;
        send_rows(1'b0, IMG_A, 8, ok);
        checks++;
        if (ok !== 1'b1) begin errors++; $display("[TB] FAIL vert_load: got timeout expected rows accepted"); end
        checks++;
        if ({busy_out, row_ready_out} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL vert_scan_busy: got busy/ready=%b expected 10", {busy_out, row_ready_out});
        end
        wait_valid(n);
        checks++;
        if (n !== 4) begin errors++; $display("[TB] FAIL vert_scan_cycles: got %0d expected 4", n); end
        checks++;
        if (beat_obs !== {1'b1, 8'h01, 1'b0, 11'd4, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL vert_beat0: got %h expected %h", beat_obs, {1'b1, 8'h01, 1'b0, 11'd4, 3'b000});
        end
        strip_ready_in = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if (beat_obs !== {1'b1, 8'h00, 1'b1, 11'd6, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL vert_beat1: got %h expected %h", beat_obs, {1'b1, 8'h00, 1'b1, 11'd6, 3'b001});
        end
        @(posedge clk_in); #1;
        strip_ready_in = 1'b0;
        checks++;
        if ({row_ready_out, busy_out, strip_valid_out} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL vert_back_to_load: got %b expected 100", {row_ready_out, busy_out, strip_valid_out});
        end
    endtask

    task automatic test_stall;
        bit ok;
        int n;
        send_rows(1'b0, IMG_A, 8, ok);
        wait_valid(n);
        checks++;
        if (ok !== 1'b1 || n !== 4) begin
            errors++;
            $display("[TB] FAIL stall_setup: got ok=%b scan=%0d expected ok=1 scan=4", ok, n);
        end
        row_valid_in = 1'b1;
        row_data_in  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_in); #1;
            checks++;
            if ({row_ready_out, beat_obs} !== {1'b0, 1'b1, 8'h01, 1'b0, 11'd4, 3'b000}) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got %h expected %h", i, {row_ready_out, beat_obs},
                         {1'b0, 1'b1, 8'h01, 1'b0, 11'd4, 3'b000});
            end
        end
        strip_ready_in = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if (beat_obs !== {1'b1, 8'h00, 1'b1, 11'd6, 3'b001}) begin
            errors++;
            $display("[TB] FAIL stall_beat1: got %h expected %h", beat_obs, {1'b1, 8'h00, 1'b1, 11'd6, 3'b001});
        end
        @(posedge clk_in); #1;
        strip_ready_in = 1'b0;
        row_valid_in   = 1'b0;
        row_data_in    = 8'h00;
        checks++;
        if ({row_ready_out, strip_valid_out} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL stall_reload: got %b expected 10", {row_ready_out, strip_valid_out});
        end
    endtask

    task automatic test_horizontal;
        bit ok;
        int n;
        send_rows(1'b1, IMG_A, 8, ok);
        wait_valid(n);
        checks++;
        if (ok !== 1'b1 || n !== 1) begin
            errors++;
            $display("[TB] FAIL horiz_scan: got ok=%b scan=%0d expected ok=1 scan=1", ok, n);
        end
        checks++;
        if (beat_obs !== {1'b1, 8'h00, 1'b0, 11'd1, 3'b000}) begin
            errors++;
            $display("[TB] FAIL horiz_beat0: got %h expected %h", beat_obs, {1'b1, 8'h00, 1'b0, 11'd1, 3'b000});
        end
        strip_ready_in = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if (beat_obs !== {1'b1, 8'h08, 1'b1, 11'd3, 3'b001}) begin
            errors++;
            $display("[TB] FAIL horiz_beat1: got %h expected %h", beat_obs, {1'b1, 8'h08, 1'b1, 11'd3, 3'b001});
        end
        @(posedge clk_in); #1;
        strip_ready_in = 1'b0;
    endtask

    task automatic test_empty;
        bit ok;
        int n;
        send_rows(1'b0, IMG_ZERO, 8, ok);
        wait_valid(n);
        checks++;
        if (ok !== 1'b1 || n !== 8) begin
            errors++;
            $display("[TB] FAIL empty_scan: got ok=%b scan=%0d expected ok=1 scan=8", ok, n);
        end
        checks++;
        if (beat_obs !== {1'b1, 8'h00, 1'b0, 11'd1, 3'b010}) begin
            errors++;
            $display("[TB] FAIL empty_beat0: got %h expected %h", beat_obs, {1'b1, 8'h00, 1'b0, 11'd1, 3'b010});
        end
        strip_ready_in = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if (beat_obs !== {1'b1, 8'h00, 1'b1, 11'd3, 3'b011}) begin
            errors++;
            $display("[TB] FAIL empty_beat1: got %h expected %h", beat_obs, {1'b1, 8'h00, 1'b1, 11'd3, 3'b011});
        end
        @(posedge clk_in); #1;
        strip_ready_in = 1'b0;
    endtask

    task automatic test_oob;
        bit ok;
        int n;
        send_rows(1'b0, IMG_COL7, 8, ok);
        wait_valid(n);
        checks++;
        if (ok !== 1'b1 || n !== 8) begin
            errors++;
            $display("[TB] FAIL oob_scan: got ok=%b scan=%0d expected ok=1 scan=8", ok, n);
        end
        checks++;
        if (beat_obs !== {1'b1, 8'h00, 1'b0, 11'd8, 3'b100}) begin
            errors++;
            $display("[TB] FAIL oob_beat0: got %h expected %h", beat_obs, {1'b1, 8'h00, 1'b0, 11'd8, 3'b100});
        end
        strip_ready_in = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if (beat_obs !== {1'b1, 8'h00, 1'b1, 11'd10, 3'b101}) begin
            errors++;
            $display("[TB] FAIL oob_beat1: got %h expected %h", beat_obs, {1'b1, 8'h00, 1'b1, 11'd10, 3'b101});
        end
        @(posedge clk_in); #1;
        strip_ready_in = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int n;
        send_rows(1'b1, IMG_FULL, 4, ok);
        #2 rst_in = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if ({row_ready_out, busy_out, beat_obs} !== 26'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got %h expected 0", {row_ready_out, busy_out, beat_obs});
        end
        #2 rst_in = 1'b0;
        @(posedge clk_in); #1;
        send_rows(1'b0, IMG_A, 8, ok);
        wait_valid(n);
        checks++;
        if (ok !== 1'b1 || n !== 4) begin
            errors++;
            $display("[TB] FAIL midreset_scan: got ok=%b scan=%0d expected ok=1 scan=4", ok, n);
        end
        checks++;
        if (beat_obs !== {1'b1, 8'h01, 1'b0, 11'd4, 3'b000}) begin
            errors++;
            $display("[TB] FAIL midreset_beat0: got %h expected %h", beat_obs, {1'b1, 8'h01, 1'b0, 11'd4, 3'b000});
        end
        strip_ready_in = 1'b1;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        strip_ready_in = 1'b0;
        checks++;
        if ({row_ready_out, strip_valid_out} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL midreset_done: got %b expected 10", {row_ready_out, strip_valid_out});
        end
    endtask

    initial begin
        test_reset();
        test_vertical();
        test_stall();
        test_horizontal();
        test_empty();
        test_oob();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/strip_extractor.md
# strip_extractor

Streams a square binary image in row by row, builds row and column occupancy, and finds the first occupied column (vertical mode) or row (horizontal mode). It then emits `NUM_STRIPS` evenly spaced test strips, offset from that anchor, over a valid/ready handshake. This block is the parametrised, sequential successor of the combinational strip finder. It feeds the strip-based feature stage ahead of the classifier.

## Interface
- `DIM`, 32: image side length in pixels (image is DIM x DIM); ≥ 2
- `NUM_STRIPS`, 4: strips emitted per frame; ≥ 2
- `OFFSET`, 2: distance from anchor to first strip
- `SPACING`, 4: distance between consecutive strips; ≥ 1
- Derived: `IW = $clog2(DIM)`, `SW = $clog2(NUM_STRIPS)`, `PW = IW + 8`
- `clk_in`  in  1  clock; all state changes on rising edge
- `rst_in`  in  1  reset, asynchronous, active-high
- `mode_in`  in  1  0 = vertical strips (columns), 1 = horizontal strips (rows); sampled with row 0
- `row_valid_in`  in  1  row beat valid
- `row_ready_out`  out  1  block accepts a row
- `row_data_in`  in  DIM  one image row; bit j = column j, column 0 leftmost; rows arrive top (row 0) first
- `strip_valid_out`  out  1  strip beat valid
- `strip_ready_in`  in  1  consumer accepts strip
- `strip_data_out`  out  DIM  vertical: bit i = pixel(row i, strip column); horizontal: bit j = pixel(strip row, column j)
- `strip_index_out`  out  SW  strip number k, 0..NUM_STRIPS-1
- `strip_pos_out`  out  PW  anchor + OFFSET + k*SPACING, unsigned, no wrap
- `strip_oob_out`  out  1  strip_pos_out ≥ DIM; strip_data_out forced 0
- `strip_empty_out`  out  1  frame had no set pixel
- `strip_last_out`  out  1  k == NUM_STRIPS-1
- `busy_out`  out  1  high in SCAN and EMIT

## Operation
- Storage: DIM x DIM frame register. Occupancy vectors: `col_occ |= row_data_in` per accepted row; `row_occ[r] = |row_data_in`.
- States: LOAD, SCAN, EMIT.
- LOAD
  - row_ready_out = 1.
  - Each beat with row_valid_in & row_ready_out stores the row at row counter r and increments r.
  - mode_in is latched when r == 0 is accepted.
  - Accepting row DIM-1 moves to SCAN.
  - Occupancy and the mode latch clear on entry to LOAD.
- SCAN
  - Counter c starts at 0 and tests one index per cycle: `col_occ[c]` (vertical) or `row_occ[c]` (horizontal).
  - First set bit: anchor = c, go to EMIT with k = 0, empty = 0.
  - c == DIM-1 with no set bit: anchor = 0, empty = 1, go to EMIT.
- EMIT
  - Presents beat k; holds it until strip_ready_in.
  - On acceptance, k increments and the next beat is presented.
  - Acceptance with strip_last_out = 1 returns to LOAD.
- Empty frame: all NUM_STRIPS beats are still emitted, with strip_data_out = 0, strip_empty_out = 1, strip_oob_out computed normally from anchor 0.
- Position arithmetic is done in PW bits and never wraps. Out-of-range positions give data 0 and oob 1.
- No back-pressure on input outside LOAD: row_ready_out = 0 in SCAN/EMIT.

## Timing
- Reset (async assert): state LOAD, r = c = k = 0, occupancy cleared. Outputs: row_ready_out 0, strip_valid_out 0, strip_data_out 0, index/pos 0, oob/empty/last 0, busy_out 0.
- First rising edge after reset release: row_ready_out = 1.
- All outputs are registered.
- SCAN with anchor a lasts a+1 cycles; empty frame lasts DIM cycles.
- strip_valid_out rises the cycle after SCAN finds/exhausts.
- While strip_valid_out & !strip_ready_in, all strip_* outputs are stable.
- Back-to-back acceptance sustains one strip per cycle.
- Last strip accepted → next cycle LOAD with row_ready_out = 1.
- Reset mid-frame or mid-EMIT aborts immediately: partial frame discarded, no further strip beats.
- row_valid_in outside LOAD is ignored; the source must hold the row until ready.

## Test plan
- DIM=8, NUM_STRIPS=2, OFFSET=1, SPACING=2, vertical. Rows 2–5 = 8'b0000_1000, row 0 = 8'b0001_0000, others 0.
  - Required: anchor 3.
  - Beat 0: pos 4, data 8'b0000_0001.
  - Beat 1: pos 6, data 0, last 1.
  - SCAN lasts 4 cycles.
- Same image, horizontal mode.
  - Required: anchor 0.
  - Beat 0: pos 1, data 0.
  - Beat 1: pos 3, data 8'b0000_1000.
- All-zero frame.
  - Required: 2 beats, empty = 1, data 0, pos 1 and 3.
  - SCAN lasts exactly 8 cycles.
- Pixel only in column 7 (vertical).
  - Required: anchor 7, pos 8 and 10, oob = 1 on both, data 0.
- strip_ready_in low for 5 cycles on beat 0, with row_valid_in held high throughout.
  - Required: beat 0 outputs stable, row_ready_out = 0.
  - After both beats, next frame loads starting at row 0.
- Assert rst_in after 4 rows accepted; release and send a full frame.
  - Required: all outputs 0 during reset.
  - New frame is processed with no residue from the first 4 rows.
